// File: rtl/odd_counter_arbiter_pkg.sv
// Shared types and constants for the odd-counter arbiter and its counter datapath.
package odd_ctr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] ODD_MIN  = 4'b0001;
    localparam logic [3:0] ODD_MAX  = 4'b1111;
    localparam logic [3:0] ODD_STEP = 4'd2;

endpackage

// File: rtl/odd_step_counter.sv
// 4-bit counter that only visits odd values, stepping by two with wrap in either direction.
module odd_step_counter
    import odd_ctr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step_en,
    input  logic       up,
    output logic [3:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= ODD_MIN;
        end else if (step_en) begin
            // An even value can only come from corruption; resync to the range end for the direction.
            if (!count[0])
                count <= up ? ODD_MIN : ODD_MAX;
            else if (up)
                count <= (count + ODD_STEP) | 4'b0001;
            else
                count <= (count - ODD_STEP) | 4'b0001;
        end
    end

endmodule

// File: rtl/odd_counter_arbiter.sv
// Round-robin arbiter that lends the shared odd counter to one of two requesters for an N-step move.
//  state | meaning
//  IDLE  | waiting for a request
//  GRANT | owner chosen, command latched at end of cycle
//  RUN   | counter stepping once per cycle
//  DONE  | completion pulse, round-robin pointer moves on
module odd_counter_arbiter
    import odd_ctr_pkg::*;
#(
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        dir,
    input  logic [STEP_W-1:0] steps0,
    input  logic [STEP_W-1:0] steps1,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              step_en,
    output logic              y_out,
    output logic              done,
    output logic [3:0]        count_out
);

    state_t            state;
    logic              rr_ptr;
    logic              owner;
    logic              pick;
    logic [STEP_W-1:0] remaining;
    logic [STEP_W-1:0] owner_steps;

    always_comb begin
        pick        = (req == 2'b11) ? rr_ptr : req[1];
        owner_steps = owner ? steps1 : steps0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= 2'b00;
            busy      <= 1'b0;
            step_en   <= 1'b0;
            y_out     <= 1'b1;
            done      <= 1'b0;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        owner <= pick;
                        grant <= pick ? 2'b10 : 2'b01;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    remaining <= owner_steps;
                    y_out     <= dir[owner];
                    if (owner_steps == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        step_en <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    remaining <= remaining - STEP_W'(1);
                    // Last step is this cycle; DONE follows with the counter already updated.
                    if (remaining == STEP_W'(1)) begin
                        step_en <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done   <= 1'b0;
                    grant  <= 2'b00;
                    busy   <= 1'b0;
                    rr_ptr <= ~owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    odd_step_counter u_counter (
        .clk     (clk),
        .reset   (reset),
        .step_en (step_en),
        .up      (y_out),
        .count   (count_out)
    );

endmodule
